// File: rtl/alu_stage.sv
// ALU stage: single-cycle ADD/SUB/logic/PASS, iterative shift-add MUL; ALU_STAGE_SAT_EN enables ADD/SUB saturation.
// Latency: 1 cycle non-MUL, WIDTH+1 cycles MUL (accept edge to first o_VALID cycle).
// Backpressure: result held while i_READY=0; o_READY=0 while busy, follows i_READY while a result is pending.
module alu_stage #(
    parameter int WIDTH = 4
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic [2:0]       i_OP,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [WIDTH-1:0] o_Y,
    output logic [2:0]       o_FLAGS
);

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;

`ifdef ALU_STAGE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [2:0]       flags_q, flags_d;

    logic [WIDTH-1:0] sum, diff, acc_step, alu_y;
    logic             add_ovf, sub_ovf, alu_v, in_xfer;

    function automatic logic [2:0] flags_of(input logic v, input logic [WIDTH-1:0] y);
        return {v, y[WIDTH-1], ~|y};
    endfunction

    assign sum     = i_A + i_B;
    assign diff    = i_A - i_B;
    assign add_ovf = (i_A[MSB] == i_B[MSB]) && (sum[MSB] != i_A[MSB]);
    assign sub_ovf = (i_A[MSB] != i_B[MSB]) && (diff[MSB] != i_A[MSB]);

    always_comb begin
        alu_y = i_A;
        alu_v = 1'b0;
        case (i_OP)
            OP_ADD: begin
                alu_y = sum;
                alu_v = add_ovf;
`ifdef ALU_STAGE_SAT_EN
                // Overflow direction follows the sign of A (both operands share it).
                if (add_ovf) alu_y = i_A[MSB] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_SUB: begin
                alu_y = diff;
                alu_v = sub_ovf;
`ifdef ALU_STAGE_SAT_EN
                if (sub_ovf) alu_y = i_A[MSB] ? SAT_MIN : SAT_MAX;
`endif
            end
            OP_NAND: alu_y = ~(i_A & i_B);
            OP_AND:  alu_y = i_A & i_B;
            OP_OR:   alu_y = i_A | i_B;
            OP_XOR:  alu_y = i_A ^ i_B;
            default: alu_y = i_A;
        endcase
    end

    assign o_VALID = (state_q == S_DONE);
    assign o_READY = (state_q == S_BUSY) ? 1'b0 :
                     (state_q == S_DONE) ? i_READY : 1'b1;
    assign in_xfer = i_VALID & o_READY;
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign o_Y     = y_q;
    assign o_FLAGS = flags_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        y_d      = y_q;
        flags_d  = flags_q;
        case (state_q)
            S_BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    y_d     = acc_step;
                    flags_d = flags_of(1'b0, acc_step);
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_READY) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A new op may land in IDLE or in DONE alongside the output transfer.
        if (in_xfer) begin
            if (i_OP == OP_MUL) begin
                mcand_d  = i_A;
                mplier_d = i_B;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = S_BUSY;
            end else begin
                y_d     = alu_y;
                flags_d = flags_of(alu_v, alu_y);
                state_d = S_DONE;
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            flags_q  <= flags_d;
        end
    end

endmodule

// File: tb/tb_alu_stage.sv
// Directed and random stimulus for alu_stage (WIDTH=4) with a result scoreboard.
module tb_alu_stage;

    logic       i_CLK, i_RSTn, i_VALID, o_READY, o_VALID, i_READY;
    logic [3:0] i_A, i_B, o_Y;
    logic [2:0] i_OP, o_FLAGS;

    int vectors = 0;
    int fails   = 0;
    logic [6:0] sb[$];
    logic [6:0] exp_r;

    alu_stage #(.WIDTH(4)) dut (
        .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_VALID(i_VALID), .o_READY(o_READY),
        .i_A(i_A), .i_B(i_B), .i_OP(i_OP), .o_VALID(o_VALID), .i_READY(i_READY),
        .o_Y(o_Y), .o_FLAGS(o_FLAGS)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    // Reference: {V,N,Z,Y} from integer arithmetic.
    function automatic logic [6:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa, sb_i, r;
        logic v;
        logic [3:0] y;
        sa = int'($signed(a));
        sb_i = int'($signed(b));
        v = 1'b0;
        r = 0;
        case (op)
            3'd0, 3'd1: begin
                r = (op == 3'd0) ? sa + sb_i : sa - sb_i;
                v = (r > 7) || (r < -8);
                y = r[3:0];
`ifdef ALU_STAGE_SAT_EN
                if (r > 7) y = 4'b0111;
                else if (r < -8) y = 4'b1000;
`endif
            end
            3'd2: y = ~(a & b);
            3'd3: y = a & b;
            3'd4: y = a | b;
            3'd5: y = a ^ b;
            3'd6: begin r = sa * sb_i; y = r[3:0]; end
            default: y = a;
        endcase
        return {v, y[3], (y == 4'd0), y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input bit expect_out);
        bit got;
        got = 1'b0;
        i_OP = op; i_A = a; i_B = b; i_VALID = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge i_CLK);
            if (o_READY) begin got = 1'b1; break; end
        end
        chk("send_accept", {31'd0, got}, 32'd1);
        if (got && expect_out) sb.push_back(model(op, a, b));
        @(posedge i_CLK); #1;
        i_VALID = 1'b0;
    endtask

    // Scoreboard: every output transfer pops one expected result.
    always @(negedge i_CLK) begin
        if (i_RSTn && o_VALID && i_READY) begin
            vectors++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_output: observed %0h expected none", {o_FLAGS, o_Y});
            end
            if (sb.size() != 0) begin
                exp_r = sb.pop_front();
                assert ({o_FLAGS, o_Y} === exp_r) else begin
                    fails++;
                    $error("FAIL result: observed %0h expected %0h", {o_FLAGS, o_Y}, exp_r);
                end
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        i_RSTn = 1'b0; i_VALID = 1'b0; i_READY = 1'b0;
        i_A = '0; i_B = '0; i_OP = '0;
        #3;
        chk("rst_valid", {31'd0, o_VALID}, 32'd0);
        chk("rst_y", {28'd0, o_Y}, 32'd0);
        chk("rst_flags", {29'd0, o_FLAGS}, 32'd0);
        chk("rst_ready", {31'd0, o_READY}, 32'd1);
        @(negedge i_CLK); i_RSTn = 1'b1;
        @(posedge i_CLK); #1;

        i_READY = 1'b1;
        send(3'd0, 4'd3, 4'd4, 1);
        chk("add_lat", {31'd0, o_VALID}, 32'd1);
        chk("add_y", {28'd0, o_Y}, 32'h7);
        send(3'd0, 4'd7, 4'd1, 1);
        send(3'd1, 4'b1000, 4'b0001, 1);
        send(3'd1, 4'd5, 4'd5, 1);
        chk("sub_z", {29'd0, o_FLAGS}, 32'b001);
        send(3'd2, 4'b1100, 4'b1010, 1);
        send(3'd7, 4'b1001, 4'b0000, 1);

        send(3'd6, 4'b0011, 4'b1110, 1);
        for (int k = 0; k < 4; k++) begin
            chk("mul_busy_rdy", {31'd0, o_READY}, 32'd0);
            chk("mul_busy_vld", {31'd0, o_VALID}, 32'd0);
            @(posedge i_CLK); #1;
        end
        chk("mul_lat", {31'd0, o_VALID}, 32'd1);
        chk("mul_y", {28'd0, o_Y}, 32'hA);
        @(posedge i_CLK); #1;

        i_READY = 1'b0;
        send(3'd0, 4'd2, 4'd3, 1);
        for (int k = 0; k < 3; k++) begin
            i_A = 4'($urandom); i_B = 4'($urandom); i_OP = 3'd5; i_VALID = 1'b1;
            @(negedge i_CLK);
            chk("bp_ready", {31'd0, o_READY}, 32'd0);
            chk("bp_valid", {31'd0, o_VALID}, 32'd1);
            chk("bp_y", {28'd0, o_Y}, 32'h5);
            @(posedge i_CLK); #1;
        end
        i_VALID = 1'b0; i_READY = 1'b1;
        @(posedge i_CLK); #1;

        for (int i = 0; i < 4; i++) begin
            i_OP = 3'd0; i_A = 4'(i * 3 + 1); i_B = 4'(7 - i * 5); i_VALID = 1'b1;
            @(negedge i_CLK);
            chk("stream_ready", {31'd0, o_READY}, 32'd1);
            if (o_READY) sb.push_back(model(i_OP, i_A, i_B));
            @(posedge i_CLK); #1;
            chk("stream_valid", {31'd0, o_VALID}, 32'd1);
        end
        i_VALID = 1'b0;
        @(posedge i_CLK); #1;

        for (int i = 0; i < 40; i++) begin
            i_VALID = ($urandom_range(0, 1) == 1);
            i_OP = 3'($urandom_range(0, 7));
            i_A = 4'($urandom); i_B = 4'($urandom);
            i_READY = ($urandom_range(0, 3) != 0);
            @(negedge i_CLK);
            if (i_VALID && o_READY) sb.push_back(model(i_OP, i_A, i_B));
            @(posedge i_CLK); #1;
        end
        i_VALID = 1'b0; i_READY = 1'b1;
        repeat (8) @(posedge i_CLK);
        #1;
        chk("drain_empty", sb.size(), 32'd0);

        send(3'd7, 4'b0110, 4'b0000, 1);
        send(3'd6, 4'b0011, 4'b1110, 0);
        @(posedge i_CLK); #3;
        i_RSTn = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, o_VALID}, 32'd0);
        chk("midrst_y", {28'd0, o_Y}, 32'd0);
        chk("midrst_flags", {29'd0, o_FLAGS}, 32'd0);
        @(negedge i_CLK); i_RSTn = 1'b1;
        @(posedge i_CLK); #1;
        chk("postrst_ready", {31'd0, o_READY}, 32'd1);
        for (int k = 0; k < 6; k++) begin
            chk("postrst_valid", {31'd0, o_VALID}, 32'd0);
            @(posedge i_CLK); #1;
        end
        chk("final_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
